// File: rtl/rop_csr_pkg.sv
// Shared types and constants for the ROP configuration front end:
// field layout, field indices, reset defaults and controller states.
package rop_csr_pkg;

    localparam int ROP_ADDR_BITS       = 32;
    localparam int ROP_PITCH_BITS      = 24;
    localparam int ROP_DEPTH_FUNC_BITS = 3;
    localparam int ROP_STENCIL_OP_BITS = 3;
    localparam int ROP_BLEND_MODE_BITS = 3;
    localparam int ROP_BLEND_FUNC_BITS = 4;
    localparam int ROP_LOGIC_OP_BITS   = 4;

    localparam logic [ROP_DEPTH_FUNC_BITS-1:0] ROP_DEPTH_FUNC_ALWAYS = 3'd7;
    localparam logic [ROP_STENCIL_OP_BITS-1:0] ROP_STENCIL_OP_KEEP   = 3'd0;
    localparam logic [ROP_BLEND_MODE_BITS-1:0] ROP_BLEND_MODE_ADD    = 3'd0;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_ZERO   = 4'd0;
    localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_ONE    = 4'd1;
    localparam logic [ROP_LOGIC_OP_BITS-1:0]   ROP_LOGIC_OP_COPY     = 4'd3;

    // Field indices, in the same order as the struct members below.
    localparam logic [4:0] ROP_CSR_ZBUF_ADDR      = 5'd0;
    localparam logic [4:0] ROP_CSR_ZBUF_PITCH     = 5'd1;
    localparam logic [4:0] ROP_CSR_CBUF_ADDR      = 5'd2;
    localparam logic [4:0] ROP_CSR_CBUF_PITCH     = 5'd3;
    localparam logic [4:0] ROP_CSR_ZFUNC          = 5'd4;
    localparam logic [4:0] ROP_CSR_SFUNC          = 5'd5;
    localparam logic [4:0] ROP_CSR_ZFAIL          = 5'd6;
    localparam logic [4:0] ROP_CSR_ZPASS          = 5'd7;
    localparam logic [4:0] ROP_CSR_SFAIL          = 5'd8;
    localparam logic [4:0] ROP_CSR_BLEND_MODE_RGB = 5'd9;
    localparam logic [4:0] ROP_CSR_BLEND_MODE_A   = 5'd10;
    localparam logic [4:0] ROP_CSR_BLEND_SRC_RGB  = 5'd11;
    localparam logic [4:0] ROP_CSR_BLEND_SRC_A    = 5'd12;
    localparam logic [4:0] ROP_CSR_BLEND_DST_RGB  = 5'd13;
    localparam logic [4:0] ROP_CSR_BLEND_DST_A    = 5'd14;
    localparam logic [4:0] ROP_CSR_BLEND_CONST    = 5'd15;
    localparam logic [4:0] ROP_CSR_LOGIC_OP       = 5'd16;

    typedef struct packed {
        logic [ROP_ADDR_BITS-1:0]       zbuf_addr;
        logic [ROP_PITCH_BITS-1:0]      zbuf_pitch;
        logic [ROP_ADDR_BITS-1:0]       cbuf_addr;
        logic [ROP_PITCH_BITS-1:0]      cbuf_pitch;
        logic [ROP_DEPTH_FUNC_BITS-1:0] zfunc;
        logic [ROP_DEPTH_FUNC_BITS-1:0] sfunc;
        logic [ROP_STENCIL_OP_BITS-1:0] zfail;
        logic [ROP_STENCIL_OP_BITS-1:0] zpass;
        logic [ROP_STENCIL_OP_BITS-1:0] sfail;
        logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_rgb;
        logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_a;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_src_rgb;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_src_a;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_dst_rgb;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_dst_a;
        logic [31:0]                    blend_const;
        logic [ROP_LOGIC_OP_BITS-1:0]   logic_op;
    } rop_csrs_t;

    localparam rop_csrs_t ROP_CSRS_DEFAULT = '{
        zbuf_addr:      '0,
        zbuf_pitch:     '0,
        cbuf_addr:      '0,
        cbuf_pitch:     '0,
        zfunc:          ROP_DEPTH_FUNC_ALWAYS,
        sfunc:          ROP_DEPTH_FUNC_ALWAYS,
        zfail:          ROP_STENCIL_OP_KEEP,
        zpass:          ROP_STENCIL_OP_KEEP,
        sfail:          ROP_STENCIL_OP_KEEP,
        blend_mode_rgb: ROP_BLEND_MODE_ADD,
        blend_mode_a:   ROP_BLEND_MODE_ADD,
        blend_src_rgb:  ROP_BLEND_FUNC_ONE,
        blend_src_a:    ROP_BLEND_FUNC_ONE,
        blend_dst_rgb:  ROP_BLEND_FUNC_ZERO,
        blend_dst_a:    ROP_BLEND_FUNC_ZERO,
        blend_const:    '0,
        logic_op:       ROP_LOGIC_OP_COPY
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } rop_csr_state_e;

endpackage

// File: rtl/rop_csr_regs.sv
// Shadow register set: write decode with per-field truncation and a
// zero-extending read mux.
module rop_csr_regs
    import rop_csr_pkg::*;
#(
    parameter int NUM_FIELDS = 17,
    parameter int ADDR_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [31:0]          rd_data,
    output rop_csrs_t            shadow
);

    rop_csrs_t shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en && (int'(wr_addr) < NUM_FIELDS)) begin
            case (5'(wr_addr))
                ROP_CSR_ZBUF_ADDR:      shadow_d.zbuf_addr      = wr_data;
                ROP_CSR_ZBUF_PITCH:     shadow_d.zbuf_pitch     = wr_data[ROP_PITCH_BITS-1:0];
                ROP_CSR_CBUF_ADDR:      shadow_d.cbuf_addr      = wr_data;
                ROP_CSR_CBUF_PITCH:     shadow_d.cbuf_pitch     = wr_data[ROP_PITCH_BITS-1:0];
                ROP_CSR_ZFUNC:          shadow_d.zfunc          = wr_data[ROP_DEPTH_FUNC_BITS-1:0];
                ROP_CSR_SFUNC:          shadow_d.sfunc          = wr_data[ROP_DEPTH_FUNC_BITS-1:0];
                ROP_CSR_ZFAIL:          shadow_d.zfail          = wr_data[ROP_STENCIL_OP_BITS-1:0];
                ROP_CSR_ZPASS:          shadow_d.zpass          = wr_data[ROP_STENCIL_OP_BITS-1:0];
                ROP_CSR_SFAIL:          shadow_d.sfail          = wr_data[ROP_STENCIL_OP_BITS-1:0];
                ROP_CSR_BLEND_MODE_RGB: shadow_d.blend_mode_rgb = wr_data[ROP_BLEND_MODE_BITS-1:0];
                ROP_CSR_BLEND_MODE_A:   shadow_d.blend_mode_a   = wr_data[ROP_BLEND_MODE_BITS-1:0];
                ROP_CSR_BLEND_SRC_RGB:  shadow_d.blend_src_rgb  = wr_data[ROP_BLEND_FUNC_BITS-1:0];
                ROP_CSR_BLEND_SRC_A:    shadow_d.blend_src_a    = wr_data[ROP_BLEND_FUNC_BITS-1:0];
                ROP_CSR_BLEND_DST_RGB:  shadow_d.blend_dst_rgb  = wr_data[ROP_BLEND_FUNC_BITS-1:0];
                ROP_CSR_BLEND_DST_A:    shadow_d.blend_dst_a    = wr_data[ROP_BLEND_FUNC_BITS-1:0];
                ROP_CSR_BLEND_CONST:    shadow_d.blend_const    = wr_data;
                ROP_CSR_LOGIC_OP:       shadow_d.logic_op       = wr_data[ROP_LOGIC_OP_BITS-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < NUM_FIELDS) begin
            case (5'(rd_addr))
                ROP_CSR_ZBUF_ADDR:      rd_data = shadow_q.zbuf_addr;
                ROP_CSR_ZBUF_PITCH:     rd_data = 32'(shadow_q.zbuf_pitch);
                ROP_CSR_CBUF_ADDR:      rd_data = shadow_q.cbuf_addr;
                ROP_CSR_CBUF_PITCH:     rd_data = 32'(shadow_q.cbuf_pitch);
                ROP_CSR_ZFUNC:          rd_data = 32'(shadow_q.zfunc);
                ROP_CSR_SFUNC:          rd_data = 32'(shadow_q.sfunc);
                ROP_CSR_ZFAIL:          rd_data = 32'(shadow_q.zfail);
                ROP_CSR_ZPASS:          rd_data = 32'(shadow_q.zpass);
                ROP_CSR_SFAIL:          rd_data = 32'(shadow_q.sfail);
                ROP_CSR_BLEND_MODE_RGB: rd_data = 32'(shadow_q.blend_mode_rgb);
                ROP_CSR_BLEND_MODE_A:   rd_data = 32'(shadow_q.blend_mode_a);
                ROP_CSR_BLEND_SRC_RGB:  rd_data = 32'(shadow_q.blend_src_rgb);
                ROP_CSR_BLEND_SRC_A:    rd_data = 32'(shadow_q.blend_src_a);
                ROP_CSR_BLEND_DST_RGB:  rd_data = 32'(shadow_q.blend_dst_rgb);
                ROP_CSR_BLEND_DST_A:    rd_data = 32'(shadow_q.blend_dst_a);
                ROP_CSR_BLEND_CONST:    rd_data = shadow_q.blend_const;
                ROP_CSR_LOGIC_OP:       rd_data = 32'(shadow_q.logic_op);
                default:                rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= ROP_CSRS_DEFAULT;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow = shadow_q;

endmodule

// File: rtl/rop_csr_unit.sv
// ROP configuration front end: shadow writes, drain-then-apply commit,
// active copy driving the pipeline, and a commit epoch counter.
//   state | meaning
//   IDLE  | accepting writes, waiting for a commit request
//   DRAIN | pipeline entry stalled, waiting for rop_idle
//   APPLY | one cycle: shadow copied to active, epoch incremented
module rop_csr_unit
    import rop_csr_pkg::*;
#(
    parameter int NUM_FIELDS = 17,
    parameter int ADDR_BITS  = 5,
    parameter int EPOCH_BITS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          csr_wr_valid,
    input  logic [ADDR_BITS-1:0]          csr_wr_addr,
    input  logic [31:0]                   csr_wr_data,
    output logic                          csr_wr_ready,
    input  logic [ADDR_BITS-1:0]          csr_rd_addr,
    output logic [31:0]                   csr_rd_data,
    input  logic                          csr_commit,
    input  logic                          rop_idle,
    output logic                          rop_stall,
    output logic [$bits(rop_csrs_t)-1:0]  rop_csrs,
    output logic [EPOCH_BITS-1:0]         csr_epoch,
    output logic                          busy
);

    rop_csr_state_e        state_q, state_d;
    rop_csrs_t             active_q, active_d;
    rop_csrs_t             shadow;
    logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  stall_q, stall_d;
    logic                  busy_q, busy_d;
    logic                  wr_en;

    assign wr_en = csr_wr_valid & wr_ready_q;

    rop_csr_regs #(
        .NUM_FIELDS (NUM_FIELDS),
        .ADDR_BITS  (ADDR_BITS)
    ) u_regs (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (csr_wr_addr),
        .wr_data (csr_wr_data),
        .rd_addr (csr_rd_addr),
        .rd_data (csr_rd_data),
        .shadow  (shadow)
    );

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        epoch_d  = epoch_q;
        case (state_q)
            ST_IDLE:  if (csr_commit) state_d = ST_DRAIN;
            ST_DRAIN: if (rop_idle)   state_d = ST_APPLY;
            ST_APPLY: begin
                active_d = shadow;
                epoch_d  = epoch_q + EPOCH_BITS'(1);
                state_d  = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        // Status outputs are registered, so derive them from the next state.
        wr_ready_d = (state_d == ST_IDLE);
        stall_d    = (state_d != ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            active_q   <= ROP_CSRS_DEFAULT;
            epoch_q    <= '0;
            wr_ready_q <= 1'b1;
            stall_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            epoch_q    <= epoch_d;
            wr_ready_q <= wr_ready_d;
            stall_q    <= stall_d;
            busy_q     <= busy_d;
        end
    end

    assign csr_wr_ready = wr_ready_q;
    assign rop_stall    = stall_q;
    assign busy         = busy_q;
    assign rop_csrs     = active_q;
    assign csr_epoch    = epoch_q;

endmodule

// File: tb/tb_rop_csr_unit.sv
// Self-checking bench for rop_csr_unit: vector table, hand-written commit
// sequences and a randomized run against a field-array reference model.
module tb_rop_csr_unit;
    import rop_csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_wr_valid;
    logic [4:0]  csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        csr_wr_ready;
    logic [4:0]  csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        csr_commit;
    logic        rop_idle;
    logic        rop_stall;
    logic [$bits(rop_csrs_t)-1:0] rop_csrs;
    logic [7:0]  csr_epoch;
    logic        busy;
    rop_csrs_t   rc;

    assign rc = rop_csrs;

    rop_csr_unit dut (
        .clk          (clk),
        .reset        (reset),
        .csr_wr_valid (csr_wr_valid),
        .csr_wr_addr  (csr_wr_addr),
        .csr_wr_data  (csr_wr_data),
        .csr_wr_ready (csr_wr_ready),
        .csr_rd_addr  (csr_rd_addr),
        .csr_rd_data  (csr_rd_data),
        .csr_commit   (csr_commit),
        .rop_idle     (rop_idle),
        .rop_stall    (rop_stall),
        .rop_csrs     (rop_csrs),
        .csr_epoch    (csr_epoch),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: plain field arrays and a commit-in-progress flag.
    int unsigned width_m [17] = '{32, 24, 32, 24, 3, 3, 3, 3, 3, 3, 3, 4, 4, 4, 4, 32, 4};
    int unsigned def_m   [17] = '{0, 0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3};
    int unsigned sh_m    [17];
    int unsigned ac_m    [17];
    int unsigned epoch_m;
    bit          pending_m;
    bit          idle_seen_m;

    function automatic int unsigned mask_of(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic rop_csrs_t pack(input int unsigned a [17]);
        rop_csrs_t p;
        p.zbuf_addr      = a[0];
        p.zbuf_pitch     = a[1][23:0];
        p.cbuf_addr      = a[2];
        p.cbuf_pitch     = a[3][23:0];
        p.zfunc          = a[4][2:0];
        p.sfunc          = a[5][2:0];
        p.zfail          = a[6][2:0];
        p.zpass          = a[7][2:0];
        p.sfail          = a[8][2:0];
        p.blend_mode_rgb = a[9][2:0];
        p.blend_mode_a   = a[10][2:0];
        p.blend_src_rgb  = a[11][3:0];
        p.blend_src_a    = a[12][3:0];
        p.blend_dst_rgb  = a[13][3:0];
        p.blend_dst_a    = a[14][3:0];
        p.blend_const    = a[15];
        p.logic_op       = a[16][3:0];
        return p;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance the model by one clock edge using the inputs presented now.
    task automatic model_edge();
        if (reset) begin
            sh_m = def_m;
            ac_m = def_m;
            epoch_m = 0;
            pending_m = 1'b0;
            idle_seen_m = 1'b0;
        end else if (!pending_m) begin
            if (csr_wr_valid && csr_wr_addr < 17)
                sh_m[csr_wr_addr] = csr_wr_data & mask_of(width_m[csr_wr_addr]);
            if (csr_commit) pending_m = 1'b1;
        end else if (!idle_seen_m) begin
            if (rop_idle) idle_seen_m = 1'b1;
        end else begin
            ac_m = sh_m;
            epoch_m = (epoch_m + 1) % 256;
            pending_m = 1'b0;
            idle_seen_m = 1'b0;
        end
    endtask

    task automatic check_all();
        int unsigned exp_rd;
        exp_rd = (csr_rd_addr < 17) ? sh_m[csr_rd_addr] : 0;
        chk("ready",  256'(csr_wr_ready), 256'(!pending_m));
        chk("stall",  256'(rop_stall),    256'(pending_m));
        chk("busy",   256'(busy),         256'(pending_m));
        chk("epoch",  256'(csr_epoch),    256'(epoch_m));
        chk("active", 256'(rop_csrs),     256'(pack(ac_m)));
        chk("rd",     256'(csr_rd_data),  256'(exp_rd));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{5'd2,  32'h8000_1000, 32'h8000_1000};
        vecs[1] = '{5'd4,  32'hFFFF_FFFF, 32'h0000_0007};
        vecs[2] = '{5'd20, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3] = '{5'd1,  32'hFFFF_FFFF, 32'h00FF_FFFF};
        vecs[4] = '{5'd16, 32'h0000_00FF, 32'h0000_000F};
        vecs[5] = '{5'd11, 32'h0000_0012, 32'h0000_0002};
        vecs[6] = '{5'd15, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7] = '{5'd6,  32'h0000_0005, 32'h0000_0005};

        reset = 1'b1; csr_wr_valid = 1'b0; csr_wr_addr = '0; csr_wr_data = '0;
        csr_rd_addr = '0; csr_commit = 1'b0; rop_idle = 1'b1;
        #1;
        tick(); tick();
        reset = 1'b0;
        tick();

        chk("rst_epoch", 256'(csr_epoch), 256'(0));
        chk("rst_ready", 256'(csr_wr_ready), 256'(1));
        chk("rst_stall", 256'(rop_stall), 256'(0));
        chk("rst_active", 256'(rop_csrs), 256'(pack(def_m)));
        for (int i = 0; i < 17; i++) begin
            csr_rd_addr = 5'(i); #1;
            chk("rst_rd", 256'(csr_rd_data), 256'(def_m[i]));
        end

        for (int i = 0; i < 8; i++) begin
            csr_wr_valid = 1'b1; csr_wr_addr = vecs[i].addr; csr_wr_data = vecs[i].wdata;
            tick();
            csr_wr_valid = 1'b0;
            csr_rd_addr = vecs[i].addr; #1;
            chk("vec_rd", 256'(csr_rd_data), 256'(vecs[i].exp_rd));
        end
        for (int i = 0; i < 17; i++) begin
            csr_rd_addr = 5'(i); #1;
            chk("shadow_rd", 256'(csr_rd_data), 256'(sh_m[i]));
        end
        chk("cbuf_precommit", 256'(rc.cbuf_addr), 256'(0));

        // Commit with the pipeline already idle: visible three cycles later.
        csr_commit = 1'b1;
        tick();
        csr_commit = 1'b0;
        chk("t1_busy", 256'(busy), 256'(1));
        tick();
        chk("t2_cbuf", 256'(rc.cbuf_addr), 256'(0));
        tick();
        chk("t3_cbuf", 256'(rc.cbuf_addr), 256'(32'h8000_1000));
        chk("t3_epoch", 256'(csr_epoch), 256'(1));

        // Drain held off for 10 cycles, with a write and a second commit attempted.
        rop_idle = 1'b0;
        csr_commit = 1'b1;
        tick();
        csr_commit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("drain_stall", 256'(rop_stall), 256'(1));
            chk("drain_ready", 256'(csr_wr_ready), 256'(0));
            csr_wr_valid = 1'b1; csr_wr_addr = 5'd0; csr_wr_data = 32'hAAAA_5555;
            csr_commit = (i == 3);
            tick();
        end
        csr_wr_valid = 1'b0; csr_commit = 1'b0;
        rop_idle = 1'b1;
        tick();
        chk("apply_stall", 256'(rop_stall), 256'(1));
        chk("apply_epoch", 256'(csr_epoch), 256'(1));
        tick();
        chk("drain_epoch", 256'(csr_epoch), 256'(2));
        chk("drain_idle", 256'(busy), 256'(0));
        csr_rd_addr = 5'd0; #1;
        chk("blocked_wr", 256'(csr_rd_data), 256'(0));

        // Reset in the middle of a drain discards the pending write.
        csr_wr_valid = 1'b1; csr_wr_addr = 5'd15; csr_wr_data = 32'h1234;
        tick();
        csr_wr_valid = 1'b0;
        rop_idle = 1'b0; csr_commit = 1'b1;
        tick();
        csr_commit = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; rop_idle = 1'b1;
        csr_rd_addr = 5'd15;
        tick();
        chk("mid_rst_stall", 256'(rop_stall), 256'(0));
        chk("mid_rst_shadow", 256'(csr_rd_data), 256'(0));
        chk("mid_rst_active", 256'(rc.blend_const), 256'(0));
        chk("mid_rst_epoch", 256'(csr_epoch), 256'(0));

        // 256 back-to-back commits wrap the epoch.
        for (int i = 0; i < 256; i++) begin
            csr_commit = 1'b1;
            tick();
            csr_commit = 1'b0;
            tick(); tick();
            if (i == 254) chk("epoch_255", 256'(csr_epoch), 256'(255));
        end
        chk("epoch_wrap", 256'(csr_epoch), 256'(0));

        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            csr_wr_valid = $urandom_range(0, 1) == 1;
            csr_wr_addr  = 5'($urandom_range(0, 31));
            csr_wr_data  = $urandom;
            csr_commit   = ($urandom_range(0, 7) == 0);
            rop_idle     = ($urandom_range(0, 3) != 0);
            csr_rd_addr  = 5'($urandom_range(0, 31));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
